trap_controller: RTL and testbench
==================================

# trap_controller

Sequencer that initiates implicit CSR traffic on trap entry and `mret`. It accepts a trap or mret request from the pipeline and reads `mtvec`/`mstatus`/`mepc` through the CSR file's implicit read slots. It then writes `mepc`, `mcause`, `mtval` and `mstatus` one at a time through the single implicit write port, and finally issues a one-cycle PC redirect. It sits between the execute/commit stage and `CSRs`, and owns the current privilege mode.

## Interface
Parameters:
- `RESET_MODE`, 2'b11, privilege mode after reset (MACHINE).

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `trap_req`  in  1  trap request; held by requester until `trap_ack`
- `trap_cause`  in  32  mcause value; bit 31 = interrupt
- `trap_epc`  in  32  faulting/interrupted PC
- `trap_tval`  in  32  mtval value
- `mret_req`  in  1  mret request; held until `mret_ack`
- `trap_ack`  out  1  one-cycle pulse, trap accepted
- `mret_ack`  out  1  one-cycle pulse, mret accepted
- `busy`  out  1  sequence in progress
- `csr_raddrs`  out  48  implicit read addresses: slot0 = 0x305, slot1 = 0x300, slot2 = 0x341, slot3 = 0
- `csr_re`  out  4  implicit read enables; 4'b0111 in IDLE, else 0
- `csr_rdata`  in  128  implicit read data, combinational from `CSRs`
- `csr_waddr`  out  12  implicit write address
- `csr_wdata`  out  32  implicit write data
- `csr_we`  out  1  implicit write enable
- `redirect_valid`  out  1  one-cycle redirect pulse
- `redirect_pc`  out  32  redirect target
- `mode`  out  2  current privilege (11 = MACHINE, 01 = SUPERV, 00 = USER)

## Operation
- States: IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, REDIRECT.
- IDLE, `trap_req` = 1:
  - Pulse `trap_ack`.
  - Latch cause, epc, tval, mtvec (slot0) and mstatus (slot1).
  - Go to W_EPC.
- IDLE, `mret_req` = 1 and `trap_req` = 0:
  - Pulse `mret_ack`.
  - Latch mstatus (slot1) and mepc (slot2).
  - Go to W_STATUS with the mret flag set.
- Both requests in the same cycle: the trap wins; mret gets no ack and must stay held.
- Requests while `busy` = 1 are ignored (no ack).
- Trap writes, one per state: W_EPC writes 0x341 ← {epc[31:2], 2'b00}; W_CAUSE writes 0x342 ← cause; W_TVAL writes 0x343 ← tval; W_STATUS writes 0x300.
- Trap mstatus update: MPIE[7] ← MIE[3], MIE[3] ← 0, MPP[12:11] ← `mode`; all other bits unchanged.
- mret mstatus update: MIE ← MPIE, MPIE ← 1, MPP ← 00; all other bits unchanged.
- REDIRECT: `redirect_valid` = 1, then return to IDLE.
  - Trap: `mode` ← MACHINE.
  - mret: `mode` ← latched MPP; reserved 2'b10 maps to USER.
- Trap target: {mtvec[31:2], 2'b00}, plus vectoring per Configuration.
- mret target: latched mepc with bits [1:0] cleared.
- All address arithmetic is 32-bit and wraps modulo 2^32.

## Timing
- Trap accepted at edge T: `csr_we` is high in cycles T+1..T+4 (epc, cause, tval, status), `redirect_valid` at T+5, IDLE at T+6. Back-to-back trap acceptance is possible at T+6.
- mret accepted at T: status write at T+1, redirect at T+2, IDLE at T+3.
- `busy` is high from T+1 through the REDIRECT cycle inclusive.
- `mode` changes at the edge ending REDIRECT.
- Reset values: state IDLE, `mode` = `RESET_MODE`. All other outputs are 0, except `csr_re` = 4'b0111 and the constant `csr_raddrs`.
- Reset mid-sequence returns to IDLE next edge with no further writes. CSR writes already performed are not undone.

## Configuration
- `TRAP_VECTORED_EN`:
  - Defined: if mtvec[1:0] = 01 and cause[31] = 1, target = base + 4·cause[30:0].
  - Undefined: always direct mode; mtvec[1:0] ignored.
- In both builds, mtvec[1:0] ∈ {10, 11} is treated as direct.

## Test plan
- Trap from USER: mtvec = 0x8000_0100, mstatus = 0x8, cause = 2, epc = 0x1004, tval = 0xDEAD → writes 0x341 = 0x1004, 0x342 = 2, 0x343 = 0xDEAD, 0x300 = 0x80 (MPP = 00); redirect 0x8000_0100 at T+5; `mode` = 11.
- mret: mstatus = 0x1880 (MPP = 11, MPIE = 1), mepc = 0x2000 → 0x300 ← 0x88 at T+1; redirect 0x2000 at T+2; `mode` = 11.
- Vectored interrupt with mtvec = 0x100 | 1, cause = 0x8000_0007 → redirect 0x11C when `TRAP_VECTORED_EN` is defined; 0x100 when undefined.
- Simultaneous `trap_req` and `mret_req` → only `trap_ack`; mret acked at T+6 while still held.
- Reset asserted in W_CAUSE → no 0x342/0x343/0x300 writes, no redirect; `mode` = 11 and `busy` = 0 next cycle.

Source files
------------

// File: rtl/trap_controller.sv
// -----------------------------------------------------------------------------
// trap_controller
//
// Sequences the implicit CSR traffic for trap entry and mret, then issues a
// one-cycle PC redirect. It owns the current privilege mode.
//
// Trap:  IDLE -> W_EPC -> W_CAUSE -> W_TVAL -> W_STATUS -> REDIRECT -> IDLE
// mret:  IDLE -> W_STATUS -> REDIRECT -> IDLE
//
// Build option:
//   TRAP_VECTORED_EN  when defined, interrupts (cause[31] = 1) taken with
//                     mtvec[1:0] = 01 jump to base + 4*cause[30:0]. When
//                     undefined, every trap goes to the mtvec base.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   trap_req            trap request, held until trap_ack
//   trap_cause/epc/tval mcause, faulting PC and mtval for the trap
//   mret_req            mret request, held until mret_ack
//   trap_ack, mret_ack  one-cycle acceptance pulses (combinational in IDLE)
//   busy                high while a sequence is in progress
//   csr_raddrs          implicit read addresses {slot3, slot2, slot1, slot0}
//   csr_re              implicit read enables, 4'b0111 in IDLE
//   csr_rdata           implicit read data, slot i at [32*i +: 32]
//   csr_waddr/wdata/we  single implicit write port
//   redirect_valid/pc   one-cycle redirect to the handler / mret target
//   mode                current privilege (11 M, 01 S, 00 U)
// -----------------------------------------------------------------------------
module trap_controller #(
    parameter logic [1:0] RESET_MODE = 2'b11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         trap_req,
    input  logic [31:0]  trap_cause,
    input  logic [31:0]  trap_epc,
    input  logic [31:0]  trap_tval,
    input  logic         mret_req,
    output logic         trap_ack,
    output logic         mret_ack,
    output logic         busy,
    output logic [47:0]  csr_raddrs,
    output logic [3:0]   csr_re,
    input  logic [127:0] csr_rdata,
    output logic [11:0]  csr_waddr,
    output logic [31:0]  csr_wdata,
    output logic         csr_we,
    output logic         redirect_valid,
    output logic [31:0]  redirect_pc,
    output logic [1:0]   mode
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;

    localparam logic [1:0] MODE_MACHINE = 2'b11;
    localparam logic [1:0] MODE_USER    = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_EPC,
        S_W_CAUSE,
        S_W_TVAL,
        S_W_STATUS,
        S_REDIRECT
    } state_t;

    // Split the packed read-data bus into its four 32-bit slots.
    logic [31:0] rdata_slot [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            assign rdata_slot[gi] = csr_rdata[32*gi +: 32];
        end
    endgenerate

    // Slot 3 is not read, and the low two bits of PCs / mtvec are always
    // cleared before use.
    logic unused_bits;
    assign unused_bits = ^{csr_rdata[127:96], csr_rdata[65:64],
                           csr_rdata[1:0], trap_epc[1:0]};

    state_t      state_q,        state_d;
    logic [1:0]  mode_q,         mode_d;
    logic        is_mret_q,      is_mret_d;
    logic [31:0] cause_q,        cause_d;
    logic [31:2] epc_q,          epc_d;      // trap epc or mret mepc
    logic [31:0] tval_q,         tval_d;
    logic [31:2] mtvec_base_q,   mtvec_base_d;
    logic [31:0] mstatus_q,      mstatus_d;
`ifdef TRAP_VECTORED_EN
    logic        vectored_q,     vectored_d;
`endif

    logic [31:0] status_new;
    logic [31:0] trap_target;
    logic [1:0]  mret_mode;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            mode_q       <= RESET_MODE;
            is_mret_q    <= 1'b0;
            cause_q      <= '0;
            epc_q        <= '0;
            tval_q       <= '0;
            mtvec_base_q <= '0;
            mstatus_q    <= '0;
`ifdef TRAP_VECTORED_EN
            vectored_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            is_mret_q    <= is_mret_d;
            cause_q      <= cause_d;
            epc_q        <= epc_d;
            tval_q       <= tval_d;
            mtvec_base_q <= mtvec_base_d;
            mstatus_q    <= mstatus_d;
`ifdef TRAP_VECTORED_EN
            vectored_q   <= vectored_d;
`endif
        end
    end

    // mstatus rewrite: trap stacks MIE into MPIE and records the old mode in
    // MPP; mret restores MIE from MPIE and drops MPP to USER.
    always_comb begin
        status_new = mstatus_q;
        if (is_mret_q) begin
            status_new[3]     = mstatus_q[7];
            status_new[7]     = 1'b1;
            status_new[12:11] = MODE_USER;
        end else begin
            status_new[7]     = mstatus_q[3];
            status_new[3]     = 1'b0;
            status_new[12:11] = mode_q;
        end
    end

    // Reserved MPP encoding 2'b10 returns to USER.
    assign mret_mode = (mstatus_q[12:11] == 2'b10) ? MODE_USER : mstatus_q[12:11];

    always_comb begin
        trap_target = {mtvec_base_q, 2'b00};
`ifdef TRAP_VECTORED_EN
        // 4*cause[30:0] modulo 2^32 only keeps cause[29:0].
        if (vectored_q) begin
            trap_target = {mtvec_base_q, 2'b00} + {cause_q[29:0], 2'b00};
        end
`endif
    end

    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        is_mret_d      = is_mret_q;
        cause_d        = cause_q;
        epc_d          = epc_q;
        tval_d         = tval_q;
        mtvec_base_d   = mtvec_base_q;
        mstatus_d      = mstatus_q;
`ifdef TRAP_VECTORED_EN
        vectored_d     = vectored_q;
`endif
        trap_ack       = 1'b0;
        mret_ack       = 1'b0;
        busy           = 1'b1;
        csr_re         = 4'b0000;
        csr_waddr      = 12'h000;
        csr_wdata      = 32'h0000_0000;
        csr_we         = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0000_0000;

        case (state_q)
            S_IDLE: begin
                busy   = 1'b0;
                csr_re = 4'b0111;
                // Acks are suppressed while reset is asserted so no request
                // is acknowledged that the reset would then discard.
                if (trap_req && !reset) begin
                    trap_ack     = 1'b1;
                    is_mret_d    = 1'b0;
                    cause_d      = trap_cause;
                    epc_d        = trap_epc[31:2];
                    tval_d       = trap_tval;
                    mtvec_base_d = rdata_slot[0][31:2];
                    mstatus_d    = rdata_slot[1];
`ifdef TRAP_VECTORED_EN
                    vectored_d   = (rdata_slot[0][1:0] == 2'b01) && trap_cause[31];
`endif
                    state_d      = S_W_EPC;
                end else if (mret_req && !reset) begin
                    mret_ack     = 1'b1;
                    is_mret_d    = 1'b1;
                    mstatus_d    = rdata_slot[1];
                    epc_d        = rdata_slot[2][31:2];
                    state_d      = S_W_STATUS;
                end
            end
            S_W_EPC: begin
                csr_we    = 1'b1;
                csr_waddr = ADDR_MEPC;
                csr_wdata = {epc_q, 2'b00};
                state_d   = S_W_CAUSE;
            end
            S_W_CAUSE: begin
                csr_we    = 1'b1;
                csr_waddr = ADDR_MCAUSE;
                csr_wdata = cause_q;
                state_d   = S_W_TVAL;
            end
            S_W_TVAL: begin
                csr_we    = 1'b1;
                csr_waddr = ADDR_MTVAL;
                csr_wdata = tval_q;
                state_d   = S_W_STATUS;
            end
            S_W_STATUS: begin
                csr_we    = 1'b1;
                csr_waddr = ADDR_MSTATUS;
                csr_wdata = status_new;
                state_d   = S_REDIRECT;
            end
            S_REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = is_mret_q ? {epc_q, 2'b00} : trap_target;
                mode_d         = is_mret_q ? mret_mode : MODE_MACHINE;
                state_d        = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign csr_raddrs = {12'h000, ADDR_MEPC, ADDR_MSTATUS, ADDR_MTVEC};
    assign mode       = mode_q;

endmodule

// File: tb/tb_trap_controller.sv
// -----------------------------------------------------------------------------
// tb_trap_controller
//
// Directed and randomized trap / mret sequences against a behavioural model.
// The bench plays the CSR file: it supplies mtvec/mstatus/mepc on csr_rdata
// from its own model state, and advances that state from the architectural
// rules rather than from what the DUT writes.
// -----------------------------------------------------------------------------
module tb_trap_controller;

    logic         clk;
    logic         reset;
    logic         trap_req;
    logic [31:0]  trap_cause;
    logic [31:0]  trap_epc;
    logic [31:0]  trap_tval;
    logic         mret_req;
    logic         trap_ack;
    logic         mret_ack;
    logic         busy;
    logic [47:0]  csr_raddrs;
    logic [3:0]   csr_re;
    logic [127:0] csr_rdata;
    logic [11:0]  csr_waddr;
    logic [31:0]  csr_wdata;
    logic         csr_we;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic [1:0]   mode;

    // Architectural model state
    logic [31:0] m_mtvec;
    logic [31:0] m_mstatus;
    logic [31:0] m_mepc;
    logic [1:0]  m_mode;

    int n_vec;
    int n_err;

    trap_controller #(.RESET_MODE(2'b11)) dut (
        .clk            (clk),
        .reset          (reset),
        .trap_req       (trap_req),
        .trap_cause     (trap_cause),
        .trap_epc       (trap_epc),
        .trap_tval      (trap_tval),
        .mret_req       (mret_req),
        .trap_ack       (trap_ack),
        .mret_ack       (mret_ack),
        .busy           (busy),
        .csr_raddrs     (csr_raddrs),
        .csr_re         (csr_re),
        .csr_rdata      (csr_rdata),
        .csr_waddr      (csr_waddr),
        .csr_wdata      (csr_wdata),
        .csr_we         (csr_we),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mode           (mode)
    );

    assign csr_rdata = {32'h0, m_mepc, m_mstatus, m_mtvec};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference rules ----------------
    function automatic logic [31:0] trap_status(input logic [31:0] s, input logic [1:0] md);
        logic [31:0] mie;
        mie = (s >> 3) & 32'h1;
        return (s & ~32'h0000_1888) | (mie << 7) | ({30'd0, md} << 11);
    endfunction

    function automatic logic [31:0] mret_status(input logic [31:0] s);
        logic [31:0] mpie;
        mpie = (s >> 7) & 32'h1;
        return (s & ~32'h0000_1888) | (mpie << 3) | 32'h80;
    endfunction

    function automatic logic [1:0] mret_target_mode(input logic [31:0] s);
        int mpp;
        mpp = int'((s >> 11) & 32'h3);
        if (mpp == 2) return 2'b00;
        return 2'(mpp);
    endfunction

    function automatic logic [31:0] trap_pc(input logic [31:0] tvec, input logic [31:0] cause);
        logic [31:0] base;
        base = tvec & 32'hFFFF_FFFC;
`ifdef TRAP_VECTORED_EN
        if ((tvec & 32'h3) == 32'h1 && cause >= 32'h8000_0000)
            base = base + (cause & 32'h7FFF_FFFF) * 32'd4;
`else
        if (cause == 32'hFFFF_FFFF) base = base; // cause has no effect on direct mode
`endif
        return base;
    endfunction

    // Called at negedge+1 of an IDLE cycle; returns at negedge+1 of the
    // IDLE cycle following the redirect.
    task automatic run_trap(input logic [31:0] c, input logic [31:0] e,
                            input logic [31:0] t, input string tag);
        logic [31:0] exp_addr [4];
        logic [31:0] exp_data [4];
        logic [31:0] exp_pc;
        logic [31:0] new_status;
        new_status  = trap_status(m_mstatus, m_mode);
        exp_addr[0] = 32'h341; exp_data[0] = e & 32'hFFFF_FFFC;
        exp_addr[1] = 32'h342; exp_data[1] = c;
        exp_addr[2] = 32'h343; exp_data[2] = t;
        exp_addr[3] = 32'h300; exp_data[3] = new_status;
        exp_pc      = trap_pc(m_mtvec, c);

        trap_req = 1'b1; trap_cause = c; trap_epc = e; trap_tval = t;
        #1;
        chk({tag, ".trap_ack"}, {31'd0, trap_ack}, 32'd1);
        chk({tag, ".mret_ack_idle"}, {31'd0, mret_ack}, 32'd0);
        chk({tag, ".csr_re"}, {28'd0, csr_re}, 32'h7);
        @(negedge clk);
        trap_req = 1'b0;
        trap_cause = $urandom; trap_epc = $urandom; trap_tval = $urandom;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk({tag, ".we"}, {31'd0, csr_we}, 32'd1);
            chk({tag, ".waddr"}, {20'd0, csr_waddr}, exp_addr[k]);
            chk({tag, ".wdata"}, csr_wdata, exp_data[k]);
            chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
            chk({tag, ".acks_busy"}, {30'd0, trap_ack, mret_ack}, 32'd0);
            @(negedge clk); #1;
        end
        chk({tag, ".redirect_valid"}, {31'd0, redirect_valid}, 32'd1);
        chk({tag, ".redirect_pc"}, redirect_pc, exp_pc);
        chk({tag, ".we_redirect"}, {31'd0, csr_we}, 32'd0);
        chk({tag, ".mode_before"}, {30'd0, mode}, {30'd0, m_mode});
        @(negedge clk); #1;
        chk({tag, ".busy_end"}, {31'd0, busy}, 32'd0);
        chk({tag, ".redirect_end"}, {31'd0, redirect_valid}, 32'd0);
        chk({tag, ".mode"}, {30'd0, mode}, 32'h3);
        $display("trap %s cause=%h epc=%h tval=%h -> pc=%h mstatus=%h", tag, c, e, t, exp_pc, new_status);
        m_mepc    = e & 32'hFFFF_FFFC;
        m_mstatus = new_status;
        m_mode    = 2'b11;
    endtask

    task automatic run_mret(input string tag);
        logic [31:0] new_status;
        logic [31:0] exp_pc;
        logic [1:0]  new_mode;
        new_status = mret_status(m_mstatus);
        exp_pc     = m_mepc & 32'hFFFF_FFFC;
        new_mode   = mret_target_mode(m_mstatus);

        mret_req = 1'b1;
        #1;
        chk({tag, ".mret_ack"}, {31'd0, mret_ack}, 32'd1);
        chk({tag, ".trap_ack_idle"}, {31'd0, trap_ack}, 32'd0);
        @(negedge clk);
        mret_req = 1'b0;
        #1;
        chk({tag, ".we"}, {31'd0, csr_we}, 32'd1);
        chk({tag, ".waddr"}, {20'd0, csr_waddr}, 32'h300);
        chk({tag, ".wdata"}, csr_wdata, new_status);
        chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
        @(negedge clk); #1;
        chk({tag, ".redirect_valid"}, {31'd0, redirect_valid}, 32'd1);
        chk({tag, ".redirect_pc"}, redirect_pc, exp_pc);
        chk({tag, ".busy_redirect"}, {31'd0, busy}, 32'd1);
        @(negedge clk); #1;
        chk({tag, ".busy_end"}, {31'd0, busy}, 32'd0);
        chk({tag, ".mode"}, {30'd0, mode}, {30'd0, new_mode});
        $display("mret %s mepc=%h -> pc=%h mstatus=%h mode=%0d", tag, m_mepc, exp_pc, new_status, new_mode);
        m_mstatus = new_status;
        m_mode    = new_mode;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        reset = 1'b1; trap_req = 1'b0; mret_req = 1'b0;
        trap_cause = '0; trap_epc = '0; trap_tval = '0;
        m_mtvec = 32'h0; m_mstatus = 32'h0; m_mepc = 32'h0; m_mode = 2'b11;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        #1;
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.mode", {30'd0, mode}, 32'h3);
        chk("rst.csr_re", {28'd0, csr_re}, 32'h7);
        chk("rst.we", {31'd0, csr_we}, 32'd0);
        chk("rst.redirect", {31'd0, redirect_valid}, 32'd0);
        chk("rst.acks", {30'd0, trap_ack, mret_ack}, 32'd0);
        chk("rst.raddr0", {20'd0, csr_raddrs[11:0]}, 32'h305);
        chk("rst.raddr1", {20'd0, csr_raddrs[23:12]}, 32'h300);
        chk("rst.raddr2", {20'd0, csr_raddrs[35:24]}, 32'h341);
        chk("rst.raddr3", {20'd0, csr_raddrs[47:36]}, 32'h0);
        $display("reset checked");
        @(negedge clk);
        reset = 1'b0;
        #1;

        // ---- drop to USER via mret with MPP = 00 ----
        m_mstatus = 32'h0000_0080; m_mepc = 32'h0000_1000;
        run_mret("to_user");

        // ---- trap from USER ----
        m_mtvec = 32'h8000_0100; m_mstatus = 32'h0000_0008;
        run_trap(32'd2, 32'h0000_1004, 32'h0000_DEAD, "trap_user");

        // ---- mret back to MACHINE ----
        m_mstatus = 32'h0000_1880; m_mepc = 32'h0000_2000;
        run_mret("mret_m");

        // ---- vectored interrupt ----
        m_mtvec = 32'h0000_0101; m_mstatus = 32'h0000_0008;
        run_trap(32'h8000_0007, 32'h0000_3000, 32'h0, "vec_irq");

        // ---- simultaneous requests: trap wins, held mret acked after ----
        m_mtvec = 32'h0000_0200; m_mstatus = 32'h0000_1888; m_mepc = 32'h0000_4000;
        mret_req = 1'b1;
        run_trap(32'd11, 32'h0000_5006, 32'h1234_5678, "both");
        run_mret("held_mret");

        // ---- reset while in W_CAUSE ----
        trap_req = 1'b1; trap_cause = 32'd5; trap_epc = 32'h6000; trap_tval = 32'h77;
        @(negedge clk); trap_req = 1'b0;
        @(negedge clk); #1;
        chk("rstmid.waddr", {20'd0, csr_waddr}, 32'h342);
        reset = 1'b1;
        @(negedge clk); #1;
        chk("rstmid.busy", {31'd0, busy}, 32'd0);
        chk("rstmid.mode", {30'd0, mode}, 32'h3);
        chk("rstmid.we", {31'd0, csr_we}, 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            chk("rstmid.we_after", {31'd0, csr_we}, 32'd0);
            chk("rstmid.redirect_after", {31'd0, redirect_valid}, 32'd0);
        end
        $display("reset mid-sequence checked");
        m_mepc = 32'h6000;   // the epc write had already happened
        m_mode = 2'b11;

        // ---- randomized sequences ----
        for (int i = 0; i < 40; i++) begin
            m_mtvec   = $urandom;
            m_mstatus = $urandom;
            m_mepc    = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                logic [31:0] c;
                c = $urandom;
                if ($urandom_range(0, 1) == 1) c = {1'b1, 21'd0, c[9:0]};
                run_trap(c, $urandom, $urandom, "rnd_trap");
            end else begin
                run_mret("rnd_mret");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
